instr_seq_player: RTL and testbench

- Parametrised successor to the KEY/SW instruction queue: one block merging instruction storage, FSM and per-slot countdown.
- Stores up to DEPTH instruction words and deletes the newest entry.
- On execute, replays the stored program in order, holding each word for TICKS cycles; single-pass or looped.
- Playback is non-destructive; sits between the debounced key pulses and the torque/direction/speed displays.

---
 rtl/instr_seq_player.sv | 152 +++++++++++++++
 tb/tb_instr_seq_player.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_seq_player.sv
// instr_seq_player
// Stores up to DEPTH instruction words and replays them in order, presenting
// each word for TICKS cycles, either once or looped until aborted. Playback
// does not consume the stored program.
//
// States
//   state  | meaning
//   S_IDLE | editing the queue (save/del/clear); outputs idle
//   S_RUN  | presenting mem[slot_idx]; execute/clear abort
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   save, del       pulses: append data_in / remove newest entry (IDLE only)
//   execute         pulse: start playback in IDLE, abort in RUN
//   clear           pulse: empty the queue (aborts playback in RUN)
//   loop            level, latched at start: repeat program until aborted
//   data_in         instruction word to store
//   instr_out       word being played, 0 when idle
//   instr_valid     high while a slot is presented
//   slot_idx        index of the slot being played
//   count           number of stored entries; empty/full derived from it
//   busy            high in RUN
//   done            one-cycle pulse on single-pass completion
//   overflow        one-cycle pulse when a save is dropped because full
module instr_seq_player #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 8,
  parameter int TICKS  = 50_000_000,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save,
  input  logic              del,
  input  logic              execute,
  input  logic              clear,
  input  logic              loop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic [AW-1:0]     slot_idx,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int TW = $clog2(TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     count_nxt;
  logic [AW-1:0]     slot_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic              loop_q, loop_nxt;
  logic              done_nxt, ovf_nxt;
  logic              mem_we;
  logic              last_slot;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign busy        = (state == S_RUN);
  assign instr_valid = busy;
  // mem cannot be written while running, so a combinational read is stable
  assign instr_out   = busy ? mem[slot_idx] : '0;
  assign last_slot   = ({1'b0, slot_idx} == (count - CW'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      slot_idx <= '0;
      timer    <= '0;
      loop_q   <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      slot_idx <= slot_nxt;
      timer    <= timer_nxt;
      loop_q   <= loop_nxt;
      done     <= done_nxt;
      overflow <= ovf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[count[AW-1:0]] <= data_in;
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    slot_nxt  = slot_idx;
    timer_nxt = timer;
    loop_nxt  = loop_q;
    done_nxt  = 1'b0;
    ovf_nxt   = 1'b0;
    mem_we    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (clear) begin
          count_nxt = '0;
        end else if (execute && !empty) begin
          state_nxt = S_RUN;
          slot_nxt  = '0;
          timer_nxt = TICK_LAST;
          loop_nxt  = loop;
        end else if (del) begin
          // del beats a simultaneous save, which is dropped silently
          if (!empty) count_nxt = count - CW'(1);
        end else if (save) begin
          if (full) begin
            ovf_nxt = 1'b1;
          end else begin
            mem_we    = 1'b1;
            count_nxt = count + CW'(1);
          end
        end
      end
      S_RUN: begin
        if (clear || execute) begin
          state_nxt = S_IDLE;
          slot_nxt  = '0;
          timer_nxt = '0;
          if (clear) count_nxt = '0;
        end else if (timer != '0) begin
          timer_nxt = timer - TW'(1);
        end else if (!last_slot) begin
          slot_nxt  = slot_idx + AW'(1);
          timer_nxt = TICK_LAST;
        end else if (loop_q) begin
          slot_nxt  = '0;
          timer_nxt = TICK_LAST;
        end else begin
          state_nxt = S_IDLE;
          slot_nxt  = '0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_seq_player.sv
// Testbench for instr_seq_player (DEPTH=4, TICKS=4, DATA_W=5). A queue-based
// model tracks stored words and elapsed cycles within the playing slot; every
// cycle all outputs are compared against it.
module tb_instr_seq_player;

  localparam int DATA_W = 5;
  localparam int DEPTH  = 4;
  localparam int TICKS  = 4;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst, save, del, execute, clear, loop;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic [AW-1:0]     slot_idx;
  logic [CW-1:0]     count;
  logic              empty, full, busy, done, overflow;

  instr_seq_player #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TICKS(TICKS)) dut (
    .clk(clk), .rst(rst), .save(save), .del(del), .execute(execute),
    .clear(clear), .loop(loop), .data_in(data_in), .instr_out(instr_out),
    .instr_valid(instr_valid), .slot_idx(slot_idx), .count(count),
    .empty(empty), .full(full), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [DATA_W-1:0] q[$];
  bit m_play, m_loop, m_done, m_ovf;
  int m_slot, m_elapsed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    m_done = 0;
    m_ovf  = 0;
    if (rst) begin
      q.delete();
      m_play = 0; m_slot = 0; m_elapsed = 0;
    end else if (!m_play) begin
      if (clear) q.delete();
      else if (execute && q.size() > 0) begin
        m_play = 1; m_slot = 0; m_elapsed = 0; m_loop = loop;
      end else if (del) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (save) begin
        if (q.size() < DEPTH) q.push_back(data_in);
        else m_ovf = 1;
      end
    end else begin
      if (clear) begin
        q.delete(); m_play = 0;
      end else if (execute) begin
        m_play = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == TICKS) begin
          m_elapsed = 0;
          if (m_slot < q.size() - 1) m_slot++;
          else if (m_loop) m_slot = 0;
          else begin m_play = 0; m_done = 1; end
        end
      end
    end
    if (!m_play) m_slot = 0;
  endtask

  task automatic compare_all();
    check("instr_out",   instr_out,   m_play ? q[m_slot] : '0);
    check("instr_valid", instr_valid, m_play);
    check("busy",        busy,        m_play);
    check("slot_idx",    slot_idx,    m_play ? m_slot : 0);
    check("count",       count,       q.size());
    check("empty",       empty,       q.size() == 0);
    check("full",        full,        q.size() == DEPTH);
    check("done",        done,        m_done);
    check("overflow",    overflow,    m_ovf);
  endtask

  task automatic step(input bit r, input bit s, input bit d, input bit e,
                      input bit c, input bit l, input logic [DATA_W-1:0] din);
    rst = r; save = s; del = d; execute = e; clear = c; loop = l; data_in = din;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic do_save(input logic [DATA_W-1:0] din);
    step(0, 1, 0, 0, 0, 0, din);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, 0, '0);
    check("rst_count", count, 0);
    check("rst_out", instr_out, 0);

    // single pass of three words
    do_save(5'h01); do_save(5'h06); do_save(5'h0B);
    check("plan_count3", count, 3);
    step(0, 0, 0, 1, 0, 0, '0);
    check("first_word", instr_out, 5'h01);
    idle(3);
    check("word0_held", instr_out, 5'h01);
    idle(1);
    check("second_word", instr_out, 5'h06);
    idle(8);
    check("done_pulse", done, 1);
    check("after_done_count", count, 3);

    // fill, overflow, delete
    step(0, 0, 0, 0, 1, 0, '0);
    for (int i = 1; i <= 4; i++) do_save(DATA_W'(i));
    check("full_flag", full, 1);
    do_save(5'h05);
    check("ovf_pulse", overflow, 1);
    step(0, 0, 1, 0, 0, 0, '0);
    check("after_del", count, 3);

    // save+del together, del on empty, execute on empty
    step(0, 0, 0, 0, 1, 0, '0);
    do_save(5'h0A); do_save(5'h0C);
    step(0, 1, 1, 0, 0, 0, 5'h11);
    check("save_del_count", count, 1);
    step(0, 0, 1, 0, 0, 0, '0);
    step(0, 0, 1, 0, 0, 0, '0);
    step(0, 0, 0, 1, 0, 0, '0);
    check("exec_empty_busy", busy, 0);

    // looped program, ignored edits, abort
    do_save(5'h02); do_save(5'h03);
    step(0, 0, 0, 1, 0, 1, '0);
    idle(5);
    step(0, 1, 0, 0, 0, 0, 5'h1F);
    step(0, 0, 1, 0, 0, 0, '0);
    idle(20);
    check("loop_busy", busy, 1);
    step(0, 0, 0, 1, 0, 0, '0);
    check("abort_count", count, 2);
    check("abort_valid", instr_valid, 0);

    // clear during run
    step(0, 0, 0, 1, 0, 1, '0);
    idle(6);
    step(0, 0, 0, 1, 1, 0, '0);
    check("clear_run_empty", empty, 1);

    // reset mid-slot
    do_save(5'h07); do_save(5'h08);
    step(0, 0, 0, 1, 0, 0, '0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, '0);
    check("rst_run_empty", empty, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int p;
      bit r, s, d, e, c;
      p = $urandom_range(0, 999);
      r = (p < 4);
      s = ($urandom_range(0, 99) < 30);
      d = ($urandom_range(0, 99) < 10);
      e = ($urandom_range(0, 99) < 6);
      c = ($urandom_range(0, 99) < 2);
      step(r, s, d, e, c, 1'($urandom_range(0, 1)), DATA_W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
